spi_mem_ctrl: RTL and testbench

//  Parametrised SPI memory master; successor to the fixed 32-bit read-only fetch path.

---
 rtl/spi_mem_pkg.sv | 31 +++
 rtl/spi_clk_gen.sv | 38 +++
 rtl/spi_mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_mem_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory master: FSM state encoding, request
// size codes, default command bytes and the size-to-byte-count helper.
package spi_mem_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  localparam logic [7:0] DEF_CMD_READ  = 8'h03;
  localparam logic [7:0] DEF_CMD_WRITE = 8'h02;

  // Reserved size code is served as a full word.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size_e'(size))
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: CLK_DIV clk cycles per half-period, idle low.
// rise/fall are one-cycle strobes high in the cycle whose closing clk edge
// makes sclk go high/low. Counter and sclk are cleared whenever en is low.
module spi_clk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  logic [15:0] cnt;

  // Half-period counter; toggles sclk when the count wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 16'd0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= 16'd0;
      sclk <= 1'b0;
    end else if (cnt == DIV_M1) begin
      cnt  <= 16'd0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 16'd1;
    end
  end

  assign rise = en && (cnt == DIV_M1) && !sclk;
  assign fall = en && (cnt == DIV_M1) &&  sclk;

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI memory master (mode 0) for instruction fetch and load/store.
// Sends command, address, then data bytes in address order, MSB first.
// Optional build macro SPI_MEM_WRITE_EN: when defined, writes go out on the
// bus with CMD_WRITE; when undefined, writes complete immediately with no
// SPI activity.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int         ADDR_W    = 24,
  parameter int         CLK_DIV   = 1,
  parameter logic [7:0] CMD_READ  = DEF_CMD_READ,
  parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  input  logic              miso
);

  localparam int SO_W = 8 + ADDR_W;

  logic [2:0]      state;
  logic            wr_q;
  logic [2:0]      nb_q;
  logic [SO_W-1:0] so_sh;
  logic [31:0]     data_sh;
  logic [7:0]      bit_cnt;
  logic [7:0]      bit_last;
  logic [7:0]      cmd;
  logic [31:0]     rd_next;
  logic            in_xfer;
  logic            sclk_rise;
  logic            sclk_fall;

  assign in_xfer   = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
  assign cs_n      = !in_xfer;
  assign req_ready = (state == ST_IDLE);
  assign busy      = !req_ready;
  assign rsp_valid = (state == ST_DONE);
  assign cmd       = req_write ? CMD_WRITE : CMD_READ;

  // mosi is a pure function of state and the shift registers, which only
  // move on sclk falling edges or phase changes, so it never moves while sclk is high.
  assign mosi = ((state == ST_CMD) || (state == ST_ADDR)) ? so_sh[SO_W-1] :
                ((state == ST_DATA) && wr_q)              ? data_sh[31]   : 1'b0;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (in_xfer),
    .sclk (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // Index of the last bit in the current phase.
  always_comb begin
    bit_last = 8'd7;
    case (state)
      ST_ADDR: bit_last = 8'(ADDR_W - 1);
      ST_DATA: bit_last = 8'({nb_q, 3'b000}) - 8'd1;
      default: bit_last = 8'd7;
    endcase
  end

  // Bytes arrive first-address-first, so the earliest byte sits highest in
  // data_sh; reverse them into little-endian order, upper bytes zero.
  always_comb begin
    rd_next = 32'd0;
    case (nb_q)
      3'd1:    rd_next = {24'd0, data_sh[7:0]};
      3'd2:    rd_next = {16'd0, data_sh[7:0], data_sh[15:8]};
      default: rd_next = {data_sh[7:0], data_sh[15:8], data_sh[23:16], data_sh[31:24]};
    endcase
  end

  // Transfer FSM: latch request, walk CMD/ADDR/DATA bit by bit, pulse DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_q      <= 1'b0;
      nb_q      <= 3'd0;
      so_sh     <= '0;
      data_sh   <= 32'd0;
      bit_cnt   <= 8'd0;
      rsp_rdata <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            nb_q    <= nbytes(req_size);
            so_sh   <= {cmd, req_addr};
            data_sh <= req_write ? {req_wdata[7:0], req_wdata[15:8],
                                    req_wdata[23:16], req_wdata[31:24]} : 32'd0;
            bit_cnt <= 8'd0;
`ifdef SPI_MEM_WRITE_EN
            state   <= ST_CMD;
`else
            state   <= req_write ? ST_DONE : ST_CMD;
`endif
          end
        end
        ST_CMD, ST_ADDR, ST_DATA: begin
          if (sclk_rise && (state == ST_DATA) && !wr_q)
            data_sh <= {data_sh[30:0], miso};
          if (sclk_fall) begin
            so_sh <= so_sh << 1;
            if ((state == ST_DATA) && wr_q)
              data_sh <= {data_sh[30:0], 1'b0};
            if (bit_cnt == bit_last) begin
              bit_cnt <= 8'd0;
              case (state)
                ST_CMD:  state <= ST_ADDR;
                ST_ADDR: state <= ST_DATA;
                default: begin
                  state <= ST_DONE;
                  if (!wr_q)
                    rsp_rdata <= rd_next;
                end
              endcase
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Testbench for spi_mem_ctrl: two instances (CLK_DIV=1 and CLK_DIV=3) with a
// behavioural SPI memory model, table-driven transfers plus hand-written
// back-to-back, slow-clock and mid-transfer reset sequences.
// Write expectations follow the SPI_MEM_WRITE_EN build macro.
module tb_spi_mem_ctrl;

  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_write = 1'b0;
  logic [23:0] req_addr = 24'd0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_valid_v = 2'b00;
  logic [1:0]  ready_v, rsp_valid_v, busy_v, sclk_v, mosi_v, cs_v;
  logic [1:0]  miso_v = 2'b00;
  logic [31:0] rdata0, rdata1;

  int total = 0;
  int bad = 0;

  // SPI memory model state, one slot per instance
  int          mcnt [2] = '{0, 0};
  logic [63:0] mlog [2] = '{64'd0, 64'd0};
  logic [31:0] mresp [2] = '{32'd0, 32'd0};
  int          cs_falls [2] = '{0, 0};
  logic [1:0]  sclk_d = 2'b00;
  logic [1:0]  cs_d = 2'b11;
  logic [1:0]  mosi_d = 2'b00;
  int          stab_bad = 0;
  int          run1 = 0;
  int          hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;

  always #5 clk = ~clk;

  spi_mem_ctrl #(.ADDR_W(24), .CLK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_v[0]), .req_ready(ready_v[0]),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[0]), .rsp_rdata(rdata0), .busy(busy_v[0]),
    .sclk(sclk_v[0]), .mosi(mosi_v[0]), .cs_n(cs_v[0]), .miso(miso_v[0])
  );

  spi_mem_ctrl #(.ADDR_W(24), .CLK_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_v[1]), .req_ready(ready_v[1]),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[1]), .rsp_rdata(rdata1), .busy(busy_v[1]),
    .sclk(sclk_v[1]), .mosi(mosi_v[1]), .cs_n(cs_v[1]), .miso(miso_v[1])
  );

  // Memory model sampled mid-cycle: logs mosi on each sclk rise, presents the
  // next read bit on miso, checks mosi stability and measures sclk phases.
  always @(negedge clk) begin
    int idx;
    for (int m = 0; m < 2; m++) begin
      if (!cs_v[m] && cs_d[m]) begin
        mcnt[m] = 0;
        mlog[m] = 64'd0;
        cs_falls[m]++;
      end
      if (!cs_v[m] && sclk_v[m] && !sclk_d[m]) begin
        mlog[m] = {mlog[m][62:0], mosi_v[m]};
        mcnt[m]++;
      end
      if (!cs_v[m] && !cs_d[m] && (mosi_v[m] !== mosi_d[m]) && !(sclk_d[m] && !sclk_v[m]))
        stab_bad++;
      if (m == 1) begin
        if (sclk_v[1] != sclk_d[1]) begin
          if (sclk_d[1]) begin
            if (run1 < hi_min) hi_min = run1;
            if (run1 > hi_max) hi_max = run1;
          end else begin
            if (run1 < lo_min) lo_min = run1;
            if (run1 > lo_max) lo_max = run1;
          end
          run1 = 1;
        end else begin
          run1++;
        end
        if (cs_v[1]) run1 = 0;
      end
      idx = mcnt[m] - 32;
      miso_v[m] = (idx >= 0 && idx < 32) ? mresp[m][(idx / 8) * 8 + 7 - (idx % 8)] : 1'b0;
      sclk_d[m] = sclk_v[m];
      cs_d[m]   = cs_v[m];
      mosi_d[m] = mosi_v[m];
    end
  end

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_bits;
    logic [63:0] exp_log;
    int          cmp_bits;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete request on instance ch; returns accept->rsp_valid latency
  // (-1 on timeout), rsp_rdata and cs_n sampled in the response cycle.
  task automatic applyStimulus(input int ch, input logic wr, input logic [23:0] addr,
                               input logic [1:0] size, input logic [31:0] wdata,
                               output int lat, output logic [31:0] rdata, output logic csn);
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    req_valid_v[ch] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_v[ch] = 1'b0;
    req_write = ~wr;
    req_addr  = ~addr;
    req_size  = ~size;
    req_wdata = ~wdata;
    lat = 1;
    while (!rsp_valid_v[ch] && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid_v[ch]) lat = -1;
    rdata = (ch == 1) ? rdata1 : rdata0;
    csn = cs_v[ch];
    @(negedge clk);
  endtask

  // Leading cmp bits of the transfer as logged by the model, left-aligned.
  function automatic logic [63:0] headBits(input logic [63:0] log, input int n, input int cmp);
    logic [63:0] al;
    logic [63:0] mask;
    al   = (n >= 64) ? log : (log << (64 - n));
    mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> cmp);
    return al & mask;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int falls;
    int rsp_seen;
    logic [31:0] rd;
    logic csn;

    vecs[0] = '{1'b0, 24'h000010, 2'd2, 32'h0, 32'h12345678, 32'h12345678, 129, 64, 64'h03000010_00000000, 32};
    vecs[1] = '{1'b0, 24'h000001, 2'd0, 32'h0, 32'h000000AB, 32'h000000AB,  81, 40, 64'h03000001_00000000, 32};
    vecs[2] = '{1'b0, 24'h00ABCD, 2'd1, 32'h0, 32'h0000CDEF, 32'h0000CDEF,  97, 48, 64'h0300ABCD_00000000, 32};
    vecs[3] = '{1'b0, 24'hFFFFFF, 2'd3, 32'h0, 32'h44332211, 32'h44332211, 129, 64, 64'h03FFFFFF_00000000, 32};
`ifdef SPI_MEM_WRITE_EN
    vecs[4] = '{1'b1, 24'h000100, 2'd2, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h44332211, 129, 64, 64'h02000100_EFBEADDE, 64};
    vecs[5] = '{1'b1, 24'h123456, 2'd1, 32'h1234A55A, 32'hFFFFFFFF, 32'h44332211,  97, 48, 64'h02123456_5AA50000, 48};
    vecs[6] = '{1'b1, 24'h00FFEE, 2'd0, 32'hFFFFFF77, 32'hFFFFFFFF, 32'h44332211,  81, 40, 64'h0200FFEE_77000000, 40};
`else
    vecs[4] = '{1'b1, 24'h000100, 2'd2, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h44332211, 1, 0, 64'h0, 0};
    vecs[5] = '{1'b1, 24'h123456, 2'd1, 32'h1234A55A, 32'hFFFFFFFF, 32'h44332211, 1, 0, 64'h0, 0};
    vecs[6] = '{1'b1, 24'h00FFEE, 2'd0, 32'hFFFFFF77, 32'hFFFFFFFF, 32'h44332211, 1, 0, 64'h0, 0};
`endif
    vecs[7] = '{1'b0, 24'h000002, 2'd0, 32'h0, 32'h0000005A, 32'h0000005A,  81, 40, 64'h03000002_00000000, 32};

    // reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", 64'(cs_v[0]), 64'd1);
    checkOutput("rst_sclk", 64'(sclk_v[0]), 64'd0);
    checkOutput("rst_mosi", 64'(mosi_v[0]), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid_v[0]), 64'd0);
    checkOutput("rst_rdata", 64'(rdata0), 64'd0);
    checkOutput("rst_ready", 64'(ready_v[0]), 64'd1);
    checkOutput("rst_busy", 64'(busy_v[0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven transfers on the CLK_DIV=1 instance
    for (int i = 0; i < 8; i++) begin
      mresp[0] = vecs[i].resp;
      falls = cs_falls[0];
      applyStimulus(0, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, lat, rd, csn);
      $display("[TB] vector %0d latency %0d rdata %08h", i, lat, rd);
      checkOutput($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      checkOutput($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      checkOutput($sformatf("v%0d_cs_n_at_rsp", i), 64'(csn), 64'd1);
      checkOutput($sformatf("v%0d_cs_frames", i), 64'(cs_falls[0] - falls),
                  (vecs[i].exp_bits > 0) ? 64'd1 : 64'd0);
      if (vecs[i].exp_bits > 0) begin
        checkOutput($sformatf("v%0d_bitcount", i), 64'(mcnt[0]), 64'(vecs[i].exp_bits));
        checkOutput($sformatf("v%0d_mosi", i), headBits(mlog[0], mcnt[0], vecs[i].cmp_bits),
                    vecs[i].exp_log);
      end
    end

    // back-to-back 1B then 2B with req_valid held high
    mresp[0] = 32'h000000AB;
    @(negedge clk);
    req_write = 1'b0;
    req_addr  = 24'h000004;
    req_size  = 2'd0;
    req_valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_addr = 24'h000008;
    req_size = 2'd1;
    lat = 1;
    while (!rsp_valid_v[0] && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b_first_latency", 64'(lat), 64'd81);
    checkOutput("b2b_first_rdata", 64'(rdata0), 64'h000000AB);
    checkOutput("b2b_ready_in_done", 64'(ready_v[0]), 64'd0);
    checkOutput("b2b_cs_n_in_done", 64'(cs_v[0]), 64'd1);
    mresp[0] = 32'h0000CDEF;
    @(negedge clk);
    checkOutput("b2b_ready_after_done", 64'(ready_v[0]), 64'd1);
    checkOutput("b2b_cs_n_accept_cycle", 64'(cs_v[0]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid_v[0] = 1'b0;
    checkOutput("b2b_cs_n_second_start", 64'(cs_v[0]), 64'd0);
    lat = 1;
    while (!rsp_valid_v[0] && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b_second_latency", 64'(lat), 64'd97);
    checkOutput("b2b_second_rdata", 64'(rdata0), 64'h0000CDEF);
    @(negedge clk);

    // CLK_DIV=3 instance, 2-byte read
    mresp[1] = 32'h00002468;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    applyStimulus(1, 1'b0, 24'h000020, 2'd1, 32'h0, lat, rd, csn);
    checkOutput("div3_latency", 64'(lat), 64'd289);
    checkOutput("div3_rdata", 64'(rd), 64'h00002468);
    checkOutput("div3_high_min", 64'(hi_min), 64'd3);
    checkOutput("div3_high_max", 64'(hi_max), 64'd3);
    checkOutput("div3_low_min", 64'(lo_min), 64'd3);
    checkOutput("div3_low_max", 64'(lo_max), 64'd3);
    checkOutput("div3_bitcount", 64'(mcnt[1]), 64'd48);
    checkOutput("div3_mosi", headBits(mlog[1], mcnt[1], 32), 64'h03000020_00000000);

    // asynchronous reset in the middle of the address phase
    mresp[0] = 32'hCAFEF00D;
    @(negedge clk);
    req_write = 1'b0;
    req_addr  = 24'h00F0F0;
    req_size  = 2'd2;
    req_valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_v[0] = 1'b0;
    repeat (29) @(negedge clk);
    checkOutput("midrst_cs_n_before", 64'(cs_v[0]), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_cs_n", 64'(cs_v[0]), 64'd1);
    checkOutput("midrst_sclk", 64'(sclk_v[0]), 64'd0);
    checkOutput("midrst_mosi", 64'(mosi_v[0]), 64'd0);
    checkOutput("midrst_rsp_valid", 64'(rsp_valid_v[0]), 64'd0);
    checkOutput("midrst_ready", 64'(ready_v[0]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid_v[0] || !cs_v[0]) rsp_seen++;
    end
    checkOutput("midrst_no_activity", 64'(rsp_seen), 64'd0);
    applyStimulus(0, 1'b0, 24'h00F0F0, 2'd2, 32'h0, lat, rd, csn);
    checkOutput("postrst_latency", 64'(lat), 64'd129);
    checkOutput("postrst_rdata", 64'(rd), 64'hCAFEF00D);
    checkOutput("postrst_mosi", headBits(mlog[0], mcnt[0], 32), 64'h0300F0F0_00000000);

    // mosi must only move where sclk falls, across every transfer above
    checkOutput("mosi_stable_violations", 64'(stab_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
